// File: rtl/fetch_unit_if.sv
// Decode-side delivery channel of the fetch unit.
//   out_valid  : head of the prefetch FIFO holds an instruction
//   out_ready  : decode accepts the head this cycle
//   out_instr  : head instruction word
//   out_pc     : PC of the head instruction
// master = fetch unit (producer), slave = decode (consumer).
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PC_WIDTH   = 4
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]   out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: DEPTH-word instruction memory with synchronous
// read and a host load port, a sequential fetch PC, and a BUF_DEPTH-entry
// prefetch FIFO delivering {pc, instr} to decode over valid/ready.
// Branch redirect restarts fetch and flushes in-flight and buffered words.
// Memory contents are provided through the host load port.
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   enable          : permit new fetch issues
//   redirect_valid  : restart fetch at redirect_pc, flushing the pipeline
//   redirect_pc     : new fetch address
//   load_en/addr/data : host write into instruction memory
//   fetch_out       : decode channel (out_valid/out_ready/out_instr/out_pc)
//   buf_count       : occupied FIFO entries
module fetch_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PC_WIDTH   = 4,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           redirect_valid,
  input  logic [PC_WIDTH-1:0]            redirect_pc,
  input  logic                           load_en,
  input  logic [PC_WIDTH-1:0]            load_addr,
  input  logic [DATA_WIDTH-1:0]          load_data,
  fetch_unit_if.master                   fetch_out,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

  localparam int unsigned DEPTH = 2**PC_WIDTH;
  localparam int unsigned CW    = $clog2(BUF_DEPTH+1);
  localparam int unsigned CW1   = CW + 1;
  localparam int unsigned PW    = $clog2(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0]   CREDIT_LIM = CW1'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic [PC_WIDTH-1:0]   rd_pc_q,    rd_pc_d;
  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         count_q,    count_d;

  logic [DATA_WIDTH-1:0] fifo_instr_q [BUF_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_q    [BUF_DEPTH];

  logic        pop, pop_eff, push, issue;
  logic [CW:0] credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // No reset: contents survive reset. NBA write gives read-before-write
  // against a fetch read of the same address in the same cycle.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    pop     = (count_q != '0) & fetch_out.out_ready;
    // Credit includes the in-flight read so a returning word always has a slot.
    credit  = {1'b0, count_q} + CW1'(inflight_q) - CW1'(pop);
    issue   = enable & ~redirect_valid & (credit < CREDIT_LIM);
    push    = inflight_q & ~redirect_valid;
    pop_eff = pop & ~redirect_valid;

    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    rd_data_d  = rd_data_q;
    rd_pc_d    = rd_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
      rd_data_d  = mem_q[fetch_pc_q];
      rd_pc_d    = fetch_pc_q;
    end
    if (push)    wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_eff) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Redirect overrides issue, push and pop.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      rd_data_q  <= '0;
      rd_pc_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_data_q  <= rd_data_d;
      rd_pc_q    <= rd_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= rd_data_q;
      fifo_pc_q[wr_ptr_q]    <= rd_pc_q;
    end
  end

  assign fetch_out.out_valid = (count_q != '0);
  assign fetch_out.out_instr = fifo_instr_q[rd_ptr_q];
  assign fetch_out.out_pc    = fifo_pc_q[rd_ptr_q];
  assign buf_count           = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int DW = 16;
  localparam int PW = 4;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          load_en;
  logic [PW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [1:0]    buf_count;

  fetch_unit_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) fif ();

  fetch_unit #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .BUF_DEPTH(BD)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .fetch_out      (fif.master),
    .buf_count      (buf_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: ordered queue of delivered words, one outstanding read,
  // fetch PC and a copy of memory. Advanced at negedge with this cycle's inputs.
  typedef struct packed {
    logic [PW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          mq[$];
  ent_t          m_inf;
  int            m_inf_v = 0;
  int            m_pc    = 0;
  logic [DW-1:0] mmem [16];

  always @(negedge clk) begin : model
    int pop;
    int occ;
    check("m_valid", fif.out_valid, mq.size() != 0);
    check("m_count", buf_count, mq.size());
    if (mq.size() != 0) begin
      check("m_pc", fif.out_pc, mq[0].pc);
      check("m_instr", fif.out_instr, mq[0].instr);
    end
    if (reset) begin
      mq.delete(); m_inf_v = 0; m_pc = 0;
    end else if (redirect_valid) begin
      mq.delete(); m_inf_v = 0; m_pc = redirect_pc;
    end else begin
      pop = (mq.size() != 0 && fif.out_ready) ? 1 : 0;
      occ = mq.size() + m_inf_v - pop;
      if (pop != 0) void'(mq.pop_front());
      if (m_inf_v != 0) mq.push_back(m_inf);
      if (enable && occ < BD) begin
        m_inf.pc    = PW'(m_pc);
        m_inf.instr = mmem[m_pc];
        m_inf_v     = 1;
        m_pc        = (m_pc + 1) % 16;
      end else begin
        m_inf_v = 0;
      end
    end
    if (load_en) mmem[load_addr] = load_data;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; fif.out_ready = 1'b0;
    redirect_valid = 1'b0; load_en = 1'b0;
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; fif.out_ready = 1'b0;
    next_cyc();
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = PW'(i); load_data = DW'(16'hA000 + i);
      next_cyc();
    end
    load_en = 1'b0;

    // 1: streaming with wrap
    apply_reset();
    enable = 1'b1; fif.out_ready = 1'b1;
    check("rst_valid", fif.out_valid, 0);
    check("rst_count", buf_count, 0);
    check("rst_pc", fif.out_pc, 0);
    check("rst_instr", fif.out_instr, 0);
    for (int c = 0; c < 20; c++) begin
      if (c < 2) check("t1_valid", fif.out_valid, 0);
      else begin
        check("t1_pc", fif.out_pc, (c - 2) % 16);
        check("t1_instr", fif.out_instr, 16'hA000 + (c - 2) % 16);
      end
      next_cyc();
    end

    // 2: backpressure fills FIFO, then release
    apply_reset();
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) fif.out_ready = 1'b1;
      if (c < 2) check("t2_valid0", fif.out_valid, 0);
      else check("t2_valid1", fif.out_valid, 1);
      if (c >= 2 && c <= 6) check("t2_hold_pc", fif.out_pc, 0);
      if (c >= 3 && c <= 5) check("t2_full", buf_count, 2);
      if (c >= 6) check("t2_order", fif.out_pc, c - 6);
      next_cyc();
    end

    // 3: redirect with buffered and in-flight words
    apply_reset();
    enable = 1'b1; fif.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      redirect_valid = (c == 5); redirect_pc = 4'd9;
      if (c == 5) check("t3_pre_pc", fif.out_pc, 3);
      if (c == 6 || c == 7) check("t3_flush", fif.out_valid, 0);
      if (c == 6) check("t3_flush_cnt", buf_count, 0);
      if (c == 8) begin check("t3_new_valid", fif.out_valid, 1); check("t3_pc9", fif.out_pc, 9); end
      if (c == 9) check("t3_pc10", fif.out_pc, 10);
      next_cyc();
    end
    redirect_valid = 1'b0;

    // 4: load collides with fetch of the same address
    apply_reset();
    enable = 1'b1; fif.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      load_en = (c == 5); load_addr = 4'd5; load_data = 16'hABCD;
      redirect_valid = (c == 9); redirect_pc = 4'd5;
      if (c == 7) begin check("t4_old_pc", fif.out_pc, 5); check("t4_old", fif.out_instr, 16'hA005); end
      if (c == 12) begin check("t4_new_pc", fif.out_pc, 5); check("t4_new", fif.out_instr, 16'hABCD); end
      if (c == 13) check("t4_next", fif.out_instr, 16'hA006);
      next_cyc();
    end
    load_en = 1'b0; redirect_valid = 1'b0;

    // 5: reset with a full FIFO
    apply_reset();
    enable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      reset = (c == 5);
      if (c == 6) fif.out_ready = 1'b1;
      if (c == 5) check("t5_full", buf_count, 2);
      if (c == 6) begin
        check("t5_valid", fif.out_valid, 0); check("t5_count", buf_count, 0);
        check("t5_pc", fif.out_pc, 0); check("t5_instr", fif.out_instr, 0);
      end
      if (c == 8) begin check("t5_restart", fif.out_pc, 0); check("t5_data", fif.out_instr, 16'hA000); end
      if (c == 13) check("t5_mem", fif.out_instr, 16'hABCD);
      next_cyc();
    end
    reset = 1'b0;

    // 6: random traffic against the model
    for (int c = 0; c < 8000; c++) begin
      enable         = ($urandom % 10) != 0;
      fif.out_ready  = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc    = PW'($urandom);
      load_en        = ($urandom % 50) == 0;
      load_addr      = PW'($urandom);
      load_data      = DW'($urandom);
      next_cyc();
    end
    enable = 1'b0; fif.out_ready = 1'b1; redirect_valid = 1'b0; load_en = 1'b0;
    repeat (5) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
